// File: rtl/kernel_out_packer.sv
// Strips FloPoCo exception bits from a 34-bit stream and packs NPACK payloads per output word.
// Counts a programmed run length, marks the final word, and raises a sticky inf/NaN flag.

module kop_lane #(
  parameter int DATAW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr,
  input  logic [DATAW-1:0] din,
  output logic [DATAW-1:0] nxt
);
  logic [DATAW-1:0] q;

  // nxt includes the element being written this cycle so a completing word can be captured whole
  assign nxt = wr ? din : q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     q <= '0;
    else if (clr) q <= '0;
    else if (wr)  q <= din;
  end
endmodule

module kernel_out_packer #(
  parameter int STREAMW = 34,
  parameter int DATAW   = 32,
  parameter int NPACK   = 4,
  parameter int CNTW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNTW-1:0]        nelems,
  input  logic                   ivalid,
  input  logic [STREAMW-1:0]     in1,
  output logic                   iready,
  output logic                   ovalid,
  output logic [NPACK*DATAW-1:0] out1,
  output logic                   olast,
  input  logic                   oready,
  output logic                   done,
  output logic                   exc_flag
);
  localparam int IW = $clog2(NPACK);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                      state, state_nxt;
  logic [CNTW-1:0]             nelems_q, count;
  logic [IW-1:0]               idx;
  logic [NPACK-1:0][DATAW-1:0] lane_nxt;
  logic                        start_acc, xfer, last_elem, word_done, in_exc;

  assign start_acc = start & ((state == S_IDLE) | (state == S_DONE));
  assign iready    = (state == S_RUN) & (~ovalid | oready);
  assign xfer      = ivalid & iready;
  assign last_elem = (count == nelems_q - CNTW'(1));
  assign word_done = xfer & ((idx == IW'(NPACK-1)) | last_elem);
  assign done      = (state == S_DONE);
  assign in_exc    = in1[STREAMW-1:STREAMW-2] inside {2'b10, 2'b11};

  for (genvar i = 0; i < NPACK; i++) begin : g_lane
    kop_lane #(.DATAW(DATAW)) u_lane (
      .clk (clk),
      .rst (rst),
      .clr (start_acc | word_done),
      .wr  (xfer && (idx == IW'(i))),
      .din (in1[DATAW-1:0]),
      .nxt (lane_nxt[i])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = (nelems == '0) ? S_DONE : S_RUN;
      S_RUN:          if (xfer && last_elem) state_nxt = S_FLUSH;
      S_FLUSH:        if (ovalid && oready) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      nelems_q <= '0;
      count    <= '0;
      idx      <= '0;
      exc_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        nelems_q <= nelems;
        count    <= '0;
        idx      <= '0;
        exc_flag <= 1'b0;
      end else if (xfer) begin
        count <= count + CNTW'(1);
        idx   <= idx + IW'(1);
        if (in_exc) exc_flag <= 1'b1;
      end
    end
  end

  // A new word may load in the same cycle the held one drains, keeping ovalid high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovalid <= 1'b0;
      olast  <= 1'b0;
      out1   <= '0;
    end else if (word_done) begin
      ovalid <= 1'b1;
      olast  <= last_elem;
      out1   <= lane_nxt;
    end else if (oready) begin
      ovalid <= 1'b0;
      olast  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_kernel_out_packer.sv
// Scoreboard bench for kernel_out_packer: directed runs push expected words, a monitor pops on handshake.

module tb_kernel_out_packer;
  logic         clk, rst, start, ivalid, iready, ovalid, olast, oready, done, exc_flag;
  logic [31:0]  nelems;
  logic [33:0]  in1;
  logic [127:0] out1;

  typedef struct packed { logic [127:0] data; logic last; } exp_t;
  exp_t sb[$];

  int n_cmp = 0, n_bad = 0, cyc = 0, last_hs = 0;

  kernel_out_packer dut (
    .clk(clk), .rst(rst), .start(start), .nelems(nelems), .ivalid(ivalid), .in1(in1),
    .iready(iready), .ovalid(ovalid), .out1(out1), .olast(olast), .oready(oready),
    .done(done), .exc_flag(exc_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every handshaken word must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      chk("olast_without_ovalid", olast & ~ovalid, 0);
      if (ovalid && oready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_word: got %0h expected none", out1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("word", out1, e.data);
          chk("olast", olast, e.last);
        end
        if (olast) last_hs = cyc;
      end
    end
  end

  task automatic push(input logic [127:0] d, input logic l);
    exp_t e;
    e.data = d; e.last = l;
    sb.push_back(e);
  endtask

  task automatic do_start(input int n);
    @(posedge clk); #1;
    start = 1'b1; nelems = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offers n_acc elements (value base+k); element exc_k carries exception code 2'b11
  task automatic drive(input int n_acc, input logic [31:0] base, input int n_total, input int exc_k);
    int   k = 0, to = 0;
    logic exp_exc = 1'b0, lat = 1'b0, acc;
    logic [31:0] v;
    while (k < n_acc && to < 300) begin
      v = base + 32'(k);
      ivalid = 1'b1;
      in1 = {(k == exc_k) ? 2'b11 : 2'b01, v};
      @(negedge clk);
      if (lat) chk("latency_ovalid", ovalid, 1);
      lat = 1'b0;
      chk("exc_flag", exc_flag, exp_exc);
      chk("done_low", done, 0);
      acc = iready;
      @(posedge clk); #1;
      if (acc) begin
        if (k == exc_k) exp_exc = 1'b1;
        lat = (k % 4 == 3) || (k == n_total - 1);
        k++;
      end
      to++;
    end
    ivalid = 1'b0;
    if (k < n_acc) begin
      n_cmp++; n_bad++;
      $display("FAIL drive_timeout: accepted %0d expected %0d", k, n_acc);
    end
    if (lat) begin
      @(negedge clk);
      chk("latency_ovalid", ovalid, 1);
    end
  endtask

  task automatic wait_done();
    int to = 0;
    @(negedge clk);
    while (!done && to < 50) begin @(negedge clk); to++; end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got 0 expected 1");
    end else chk("done_timing", cyc - last_hs, 1);
  endtask

  task automatic stall();
    int to = 0;
    logic [127:0] held;
    @(negedge clk);
    while (!ovalid && to < 100) begin @(negedge clk); to++; end
    chk("stall_ovalid_seen", ovalid, 1);
    held = out1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_iready", iready, 0);
      chk("stall_out1", out1, held);
      chk("stall_ovalid", ovalid, 1);
    end
    @(posedge clk); #1;
    oready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; start = 1'b0; nelems = '0; ivalid = 1'b0; in1 = '0; oready = 1'b1;
    #3;
    chk("rst_iready", iready, 0);
    chk("rst_ovalid", ovalid, 0);
    chk("rst_olast", olast, 0);
    chk("rst_out1", out1, 0);
    chk("rst_done", done, 0);
    chk("rst_exc", exc_flag, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // T1: two full words, olast on the second
    push({32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
    push({32'd8, 32'd7, 32'd6, 32'd5}, 1'b1);
    do_start(8);
    drive(8, 32'd1, 8, -1);
    wait_done();

    // T2: partial final word, upper lanes zero
    push({32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
    push({32'd0, 32'd0, 32'd6, 32'd5}, 1'b1);
    do_start(6);
    drive(6, 32'd1, 6, -1);
    wait_done();

    // T3: downstream stall while first word is held
    push({32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
    push({32'd8, 32'd7, 32'd6, 32'd5}, 1'b1);
    oready = 1'b0;
    do_start(8);
    fork
      drive(8, 32'd1, 8, -1);
      stall();
    join
    wait_done();

    // T4: element 3 carries inf/NaN code
    push({32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
    push({32'd8, 32'd7, 32'd6, 32'd5}, 1'b1);
    do_start(8);
    drive(8, 32'd1, 8, 2);
    wait_done();
    chk("exc_end_of_run", exc_flag, 1);

    // T5: empty run
    do_start(0);
    @(negedge clk);
    chk("t5_done", done, 1);
    chk("t5_exc_cleared", exc_flag, 0);
    repeat (3) begin
      @(negedge clk);
      chk("t5_iready", iready, 0);
      chk("t5_ovalid", ovalid, 0);
    end

    // T6: reset mid-run, then a fresh short run
    do_start(8);
    drive(3, 32'h50, 8, -1);
    rst = 1'b0;
    #1;
    chk("t6_iready", iready, 0);
    chk("t6_ovalid", ovalid, 0);
    chk("t6_olast", olast, 0);
    chk("t6_out1", out1, 0);
    chk("t6_done", done, 0);
    chk("t6_exc", exc_flag, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    push({32'h104, 32'h103, 32'h102, 32'h101}, 1'b1);
    do_start(4);
    drive(4, 32'h101, 4, -1);
    wait_done();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
